winograd_tile_ctrl: RTL
=======================

Name: winograd_tile_ctrl

Overview:
- Sequencing controller for the per-channel line buffer that feeds Winograd F(m×m, n×n) input-tile transforms.
- Admits the pixel stream, fills all M channel rows, then issues one read advance per tile handshake until the row is exhausted.
- Clears the line buffer pointers and repeats for H rows per frame.
- Sits between the pixel source, the line buffer, and the downstream input-transform stage; carries no pixel data itself.

Parameters:
- M, 3, number of channels (rows held in the line buffer)
- W, 512, image width in pixels
- n, 4, input tile width
- m, 2, output tile width and tile stride
- H, 512, rows per frame
- Legal values: W ≥ n, (W-n)%m==0, H ≥ 1. A static assertion enforces these.
- Derived: T = (W-n)/m + 1 tiles per row.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  frame start, sampled in IDLE only
- i_abort  in  1  synchronous abort, any state
- i_pix_valid  in  1  source pixel valid
- o_pix_ready  out  1  controller accepts pixel
- o_lb_wr_valid  out  1  line buffer write enable
- o_lb_rd_adv  out  1  line buffer read-pointer advance (+m)
- o_lb_clr  out  1  line buffer pointer clear pulse; ORed with i_rst at the line buffer
- o_tile_valid  out  1  line buffer output holds a valid tile
- i_tile_ready  in  1  downstream consumes tile
- o_tile_col  out  $clog2(T)  index of current tile in row
- o_row_idx  out  $clog2(H)  current row index
- o_frame_done  out  1  one-cycle pulse after the last row's clear
- o_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, FILL, DRAIN, SETTLE, CLEAR. Reset enters IDLE with all counters 0 and all outputs 0.
- IDLE:
  - All outputs 0.
  - i_start=1 → FILL with row_idx=0.
- FILL:
  - o_pix_ready=1.
  - o_lb_wr_valid = i_pix_valid & o_pix_ready, combinational.
  - pix_cnt (width $clog2(M*W)) increments on each accept.
  - The accept at pix_cnt==M*W-1 → SETTLE and clears pix_cnt. o_pix_ready is 0 from the next cycle.
- SETTLE:
  - One cycle; no outputs asserted.
  - Covers the line buffer write latency so the final pixel is visible before the first read.
  - Next state is DRAIN.
- DRAIN:
  - o_tile_valid=1; o_tile_col = tile_cnt.
  - o_lb_rd_adv = o_tile_valid & i_tile_ready, combinational.
  - On handshake, tile_cnt increments. The line buffer output reflects the new tile on the following cycle; o_tile_valid stays high with no bubble.
  - Handshake at tile_cnt==T-1 → CLEAR; tile_cnt=0.
  - i_tile_ready low holds state and o_tile_col unchanged.
- CLEAR:
  - o_lb_clr=1 for exactly one cycle.
  - If row_idx==H-1: o_frame_done=1 in the same cycle, row_idx=0, → IDLE.
  - Otherwise: row_idx++, → FILL.
- i_abort has priority over all transitions. From FILL, SETTLE or DRAIN it → CLEAR with counters zeroed, and o_frame_done is not asserted. From IDLE or CLEAR it is ignored.
- No pixel is accepted outside FILL. No advance is issued outside DRAIN.
- o_lb_wr_valid and o_lb_rd_adv are never high in the same cycle.
- i_start outside IDLE is ignored.
- Asynchronous reset mid-frame returns to IDLE immediately and drops every output to 0. The line buffer is reset by the same i_rst.
- All counters saturate-free. Terminal compares use exact equality, with widths sized by $clog2 of (terminal+1).

Decomposition:
- Package winograd_pkg holds:
  - state typedef tile_ctrl_state_e
  - helper function tiles_per_row(W,n,m)
  - legality-check macro or function, shared with the transform blocks
- Sub-module: none needed; one FSM plus three counters (pix_cnt, tile_cnt, row_idx) in a single module.

Test Plan:
- Bench parameters: M=2, W=8, n=4, m=2, H=2, so T=3.
1. Reset then i_start, stream 16 pixels with i_pix_valid=1 → 16 o_lb_wr_valid pulses. o_pix_ready falls after the 16th. One SETTLE cycle follows, then o_tile_valid=1 with o_tile_col=0.
2. DRAIN with i_tile_ready=1 → o_lb_rd_adv high for 3 consecutive cycles, o_tile_col 0,1,2. o_lb_clr pulses next cycle; o_row_idx 0→1; FILL resumes.
3. Second row complete → o_lb_clr and o_frame_done pulse in the same cycle. State returns to IDLE, o_busy=0, and o_row_idx reads 0.
4. Backpressure: i_tile_ready toggles 1,0,0,1,1 → exactly 3 advances. o_tile_col holds during the stalls; no advance while i_tile_ready=0.
5. Gappy input (i_pix_valid every other cycle) plus i_start pulsed mid-FILL → still exactly 16 writes, and i_start has no effect.
6. i_abort after 5 pixels → CLEAR pulse next cycle, then FILL with pix_cnt=0 and no o_frame_done. Async i_rst during DRAIN → all outputs 0 the same cycle.

Source files
------------

// File: rtl/winograd_pkg.sv
// ============================================================================
// winograd_pkg : shared types and parameter helpers for the Winograd blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package winograd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_CLEAR  = 3'd4
    } tile_ctrl_state_e;

    function automatic int tiles_per_row(input int w, input int n, input int m);
        return (w - n) / m + 1;
    endfunction

    function automatic bit params_legal(input int w, input int n, input int m, input int h);
        return (m > 0) && (w >= n) && (((w - n) % m) == 0) && (h >= 1);
    endfunction

    // Counter width for a range 0..count-1, never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage

`default_nettype wire

// File: rtl/winograd_tile_ctrl_if.sv
// ============================================================================
// winograd_tile_ctrl_if : pixel, line-buffer and tile handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface winograd_tile_ctrl_if #(
    parameter int COL_W = 8,
    parameter int ROW_W = 9
);
    logic             i_start;
    logic             i_abort;
    logic             i_pix_valid;
    logic             i_tile_ready;
    logic             o_pix_ready;
    logic             o_lb_wr_valid;
    logic             o_lb_rd_adv;
    logic             o_lb_clr;
    logic             o_tile_valid;
    logic [COL_W-1:0] o_tile_col;
    logic [ROW_W-1:0] o_row_idx;
    logic             o_frame_done;
    logic             o_busy;

    modport master (
        input  i_start, i_abort, i_pix_valid, i_tile_ready,
        output o_pix_ready, o_lb_wr_valid, o_lb_rd_adv, o_lb_clr, o_tile_valid,
               o_tile_col, o_row_idx, o_frame_done, o_busy
    );

    modport slave (
        output i_start, i_abort, i_pix_valid, i_tile_ready,
        input  o_pix_ready, o_lb_wr_valid, o_lb_rd_adv, o_lb_clr, o_tile_valid,
               o_tile_col, o_row_idx, o_frame_done, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/winograd_tile_ctrl.sv
// ============================================================================
// winograd_tile_ctrl : line-buffer fill/drain sequencer for Winograd input tiles
// Rev 1.0
// ============================================================================
`default_nettype none

module winograd_tile_ctrl
    import winograd_pkg::*;
#(
    parameter int M      = 3,
    parameter int W      = 512,
    parameter int TILE_N = 4,
    parameter int TILE_M = 2,
    parameter int H      = 512
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    winograd_tile_ctrl_if.master bus
);

    localparam int T     = tiles_per_row(W, TILE_N, TILE_M);
    localparam int PIX_W = cnt_width(M * W);
    localparam int COL_W = cnt_width(T);
    localparam int ROW_W = cnt_width(H);

    localparam logic [PIX_W-1:0] c_PIX_LAST = PIX_W'(M * W - 1);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(T - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(H - 1);

    if (!params_legal(W, TILE_N, TILE_M, H)) begin : g_param_check
        $error("winograd_tile_ctrl: illegal W/TILE_N/TILE_M/H combination");
    end

    tile_ctrl_state_e r_state;
    tile_ctrl_state_e w_state_nxt;

    logic [PIX_W-1:0] r_pix_cnt;
    logic [COL_W-1:0] r_tile_cnt;
    logic [ROW_W-1:0] r_row_idx;
    logic             r_aborted;

    logic w_pix_ready;
    logic w_tile_valid;
    logic w_lb_clr;
    logic w_frame_done;
    logic w_pix_acc;
    logic w_tile_hs;
    logic w_abort_take;
    logic w_row_last;

    assign w_pix_acc    = w_pix_ready & bus.i_pix_valid;
    assign w_tile_hs    = w_tile_valid & bus.i_tile_ready;
    assign w_row_last   = (r_row_idx == c_ROW_LAST);
    assign w_abort_take = bus.i_abort &
                          ((r_state == ST_FILL) || (r_state == ST_SETTLE) || (r_state == ST_DRAIN));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.i_start) w_state_nxt = ST_FILL;
            ST_FILL:   if (w_pix_acc && (r_pix_cnt == c_PIX_LAST)) w_state_nxt = ST_SETTLE;
            ST_SETTLE: w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_tile_hs && (r_tile_cnt == c_COL_LAST)) w_state_nxt = ST_CLEAR;
            ST_CLEAR:  w_state_nxt = (!r_aborted && w_row_last) ? ST_IDLE : ST_FILL;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_abort_take) begin
            w_state_nxt = ST_CLEAR;
        end
    end

    always_comb begin
        w_pix_ready  = 1'b0;
        w_tile_valid = 1'b0;
        w_lb_clr     = 1'b0;
        w_frame_done = 1'b0;
        unique case (r_state)
            ST_FILL:  w_pix_ready  = 1'b1;
            ST_DRAIN: w_tile_valid = 1'b1;
            ST_CLEAR: begin
                w_lb_clr     = 1'b1;
                w_frame_done = !r_aborted && w_row_last;
            end
            default: ;
        endcase
    end

    // An aborted row restarts the frame at row 0 instead of advancing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix_cnt  <= '0;
            r_tile_cnt <= '0;
            r_row_idx  <= '0;
            r_aborted  <= 1'b0;
        end else if (w_abort_take) begin
            r_pix_cnt  <= '0;
            r_tile_cnt <= '0;
            r_row_idx  <= '0;
            r_aborted  <= 1'b1;
        end else begin
            if (w_pix_acc) begin
                r_pix_cnt <= (r_pix_cnt == c_PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
            end
            if (w_tile_hs) begin
                r_tile_cnt <= (r_tile_cnt == c_COL_LAST) ? '0 : r_tile_cnt + 1'b1;
            end
            if (r_state == ST_CLEAR) begin
                r_aborted <= 1'b0;
                r_row_idx <= (r_aborted || w_row_last) ? '0 : r_row_idx + 1'b1;
            end
        end
    end

    assign bus.o_pix_ready   = w_pix_ready;
    assign bus.o_lb_wr_valid = w_pix_acc;
    assign bus.o_lb_rd_adv   = w_tile_hs;
    assign bus.o_lb_clr      = w_lb_clr;
    assign bus.o_tile_valid  = w_tile_valid;
    assign bus.o_tile_col    = r_tile_cnt;
    assign bus.o_row_idx     = r_row_idx;
    assign bus.o_frame_done  = w_frame_done;
    assign bus.o_busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire
